// File: rtl/mo_picture_shifter_pkg.sv
// Shared constants and types for the motion-object picture shifter.
`timescale 1ns/1ps
package mo_picture_shifter_pkg;

    localparam int MO_PLANES = 4;   // bit-planes per pixel
    localparam int MO_PIX    = 8;   // pixels per graphics word
    localparam int MO_CW     = 3;   // palette-select width

    // Colour 0 with all pixel bits set is the transparent code seen by the line buffer.
    localparam logic [MO_CW+MO_PLANES-1:0] MO_TRANSPARENT = {{MO_CW{1'b0}}, {MO_PLANES{1'b1}}};

    // One graphics fetch as delivered on a gld strobe.
    typedef struct packed {
        logic [MO_PLANES*MO_PIX-1:0] gfx;
        logic                        hflip;
        logic [MO_CW-1:0]            color;
    } mo_gfx_t;

endpackage

// File: rtl/mo_picture_shifter_bitplane_shreg.sv
// One bit-plane of the active shifter. The first pixel of a word is taken
// straight from the parallel input at load time, so the register keeps only
// the pixels still to come and next_o is always the pixel for the next shift.
`timescale 1ns/1ps
module mo_picture_shifter_bitplane_shreg #(
    parameter int PIX = 8
) (
    input  logic           clk,
    input  logic           load_i,      // parallel load of a new word
    input  logic           shift_i,     // advance one pixel
    input  logic           load_dir_i,  // direction of the word being loaded (1 = right-to-left)
    input  logic [PIX-1:0] din_i,
    output logic           first_o,     // pixel emitted on the load edge
    output logic           next_o       // pixel emitted on the next shift edge
);

    logic [PIX-1:0] sr_q, sr_d;
    logic           dir_q, dir_d;

    // Next-state: load skips the pixel that first_o emits; shift moves toward the output end.
    always_comb begin
        sr_d  = sr_q;
        dir_d = dir_q;
        if (load_i) begin
            dir_d = load_dir_i;
            sr_d  = load_dir_i ? {1'b0, din_i[PIX-1:1]} : {din_i[PIX-2:0], 1'b0};
        end else if (shift_i) begin
            sr_d  = dir_q ? {1'b0, sr_q[PIX-1:1]} : {sr_q[PIX-2:0], 1'b0};
        end
    end

    // Pixel data only; validity is tracked by the counter in the parent.
    always_ff @(posedge clk) begin
        sr_q  <= sr_d;
        dir_q <= dir_d;
    end

    assign first_o = load_dir_i ? din_i[0] : din_i[PIX-1];
    assign next_o  = dir_q ? sr_q[0] : sr_q[PIX-1];

endmodule

// File: rtl/mo_picture_shifter.sv
// Motion-object picture shifter: a holding register captures one graphics
// fetch while the active shifter serialises the previous word into
// {colour, pixel} codes for the motion-object line buffer.
`timescale 1ns/1ps
module mo_picture_shifter
    import mo_picture_shifter_pkg::*;
#(
    parameter int PLANES = MO_PLANES,
    parameter int PIX    = MO_PIX,
    parameter int CW     = MO_CW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pix_en,
    input  logic                  gld,
    input  logic [PLANES*PIX-1:0] gfx,
    input  logic                  hflip,
    input  logic [CW-1:0]         color,
    input  logic                  ovf_clr,
    output logic [CW+PLANES-1:0]  mosr,
    output logic                  busy,
    output logic                  hold_full,
    output logic                  ovf
);

    localparam int                    CNTW     = $clog2(PIX + 1);
    localparam logic [CNTW-1:0]       CNT_FULL = CNTW'(PIX);
    localparam logic [CNTW-1:0]       CNT_ONE  = CNTW'(1);
    localparam logic [CW+PLANES-1:0]  TRANSP   = {{CW{1'b0}}, {PLANES{1'b1}}};

    // Holding register
    logic [PLANES*PIX-1:0] hold_gfx_q;
    logic                  hold_hflip_q;
    logic [CW-1:0]         hold_color_q;
    logic                  hold_valid_q, hold_valid_d;

    // Active shifter control
    logic [CNTW-1:0]       cnt_q, cnt_d;
    logic [CW-1:0]         act_color_q;
    logic [CW+PLANES-1:0]  mosr_q, mosr_d;
    logic                  ovf_q, ovf_d;

    logic                  do_shift, do_xfer, do_blank;
    logic [PLANES-1:0]     first_bits, next_bits;

    // Pixel-edge decisions: keep shifting, refill from HOLD, or blank on underrun.
    always_comb begin
        do_shift = pix_en && (cnt_q > CNT_ONE);
        do_xfer  = pix_en && (cnt_q <= CNT_ONE) && hold_valid_q;
        do_blank = pix_en && (cnt_q <= CNT_ONE) && !hold_valid_q;
    end

    genvar p;
    generate
        for (p = 0; p < PLANES; p++) begin : g_plane
            mo_picture_shifter_bitplane_shreg #(.PIX(PIX)) u_shreg (
                .clk        (clk),
                .load_i     (do_xfer),
                .shift_i    (do_shift),
                .load_dir_i (hold_hflip_q),
                .din_i      (hold_gfx_q[p*PIX +: PIX]),
                .first_o    (first_bits[p]),
                .next_o     (next_bits[p])
            );
        end
    endgenerate

    // Next-state for HOLD valid, pixel counter, output code and sticky overflow.
    always_comb begin
        hold_valid_d = hold_valid_q;
        cnt_d        = cnt_q;
        mosr_d       = mosr_q;
        ovf_d        = ovf_q;

        if (gld)
            hold_valid_d = 1'b1;     // a load on the transfer edge keeps HOLD full
        else if (do_xfer)
            hold_valid_d = 1'b0;

        if (do_shift) begin
            cnt_d  = cnt_q - CNT_ONE;
            mosr_d = {act_color_q, next_bits};
        end else if (do_xfer) begin
            cnt_d  = CNT_FULL;
            mosr_d = {hold_color_q, first_bits};
        end else if (do_blank) begin
            cnt_d  = '0;
            mosr_d = TRANSP;
        end

        // A set on the same edge as a clear wins.
        if (gld && hold_valid_q && !do_xfer)
            ovf_d = 1'b1;
        else if (ovf_clr)
            ovf_d = 1'b0;
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid_q <= 1'b0;
            cnt_q        <= '0;
            mosr_q       <= TRANSP;
            ovf_q        <= 1'b0;
        end else begin
            hold_valid_q <= hold_valid_d;
            cnt_q        <= cnt_d;
            mosr_q       <= mosr_d;
            ovf_q        <= ovf_d;
        end
    end

    // Word data: HOLD captures on gld, active colour follows a transfer.
    always_ff @(posedge clk) begin
        if (gld) begin
            hold_gfx_q   <= gfx;
            hold_hflip_q <= hflip;
            hold_color_q <= color;
        end
        if (do_xfer)
            act_color_q <= hold_color_q;
    end

    assign mosr      = mosr_q;
    assign busy      = (cnt_q != '0);
    assign hold_full = hold_valid_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_mo_picture_shifter.sv
// Bench for mo_picture_shifter: a word-level reference model expands each
// transferred word into its pixel list; a compare process checks every cycle,
// and directed sequences pin exact pixel codes.
`timescale 1ns/1ps
module tb_mo_picture_shifter;
    import mo_picture_shifter_pkg::*;

    localparam int MW = MO_CW + MO_PLANES;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        pix_en, gld, hflip, ovf_clr;
    logic [MO_PLANES*MO_PIX-1:0] gfx;
    logic [MO_CW-1:0]            color;
    logic [MW-1:0]               mosr;
    logic                        busy, hold_full, ovf;

    mo_picture_shifter dut (
        .clk       (clk),
        .reset     (reset),
        .pix_en    (pix_en),
        .gld       (gld),
        .gfx       (gfx),
        .hflip     (hflip),
        .color     (color),
        .ovf_clr   (ovf_clr),
        .mosr      (mosr),
        .busy      (busy),
        .hold_full (hold_full),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    mo_gfx_t     m_hold;
    bit          m_hvalid;
    logic [MW-1:0] m_pix[$];
    logic [MW-1:0] m_mosr;
    bit          m_shown;
    bit          m_ovf;
    bit          m_xfer;

    function automatic logic [MW-1:0] pix_of(input mo_gfx_t w, input int i);
        int c;
        logic [MO_PLANES-1:0] px;
        c = w.hflip ? i : MO_PIX - 1 - i;
        for (int b = 0; b < MO_PLANES; b++) px[b] = w.gfx[b*MO_PIX + c];
        return {w.color, px};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hvalid = 1'b0;
            m_pix.delete();
            m_mosr   = MO_TRANSPARENT;
            m_shown  = 1'b0;
            m_ovf    = 1'b0;
        end else begin
            m_xfer = pix_en && (m_pix.size() == 0) && m_hvalid;
            if (pix_en) begin
                if (m_pix.size() > 0) begin
                    m_mosr = m_pix.pop_front();
                end else if (m_hvalid) begin
                    for (int i = 0; i < MO_PIX; i++) m_pix.push_back(pix_of(m_hold, i));
                    m_mosr  = m_pix.pop_front();
                    m_shown = 1'b1;
                end else begin
                    m_mosr  = MO_TRANSPARENT;
                    m_shown = 1'b0;
                end
            end
            if (gld && m_hvalid && !m_xfer) m_ovf = 1'b1;
            else if (ovf_clr)               m_ovf = 1'b0;
            if (gld) begin
                m_hold.gfx   = gfx;
                m_hold.hflip = hflip;
                m_hold.color = color;
                m_hvalid     = 1'b1;
            end else if (m_xfer) begin
                m_hvalid = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mosr",      32'(mosr),      32'(m_mosr));
            chk("busy",      32'(busy),      32'(m_shown));
            chk("hold_full", 32'(hold_full), 32'(m_hvalid));
            chk("ovf",       32'(ovf),       32'(m_ovf));
        end
    end

    // ---------------- stimulus ----------------
    logic [MW-1:0]               s[9];
    logic [MO_PLANES*MO_PIX-1:0] w1;

    task automatic load_word(input logic [MO_PLANES*MO_PIX-1:0] g, input logic hf, input logic [MO_CW-1:0] c);
        gfx = g; hflip = hf; color = c; gld = 1'b1;
    endtask

    task automatic pulse_reset_check(input string tag);
        @(negedge clk);
        gld = 1'b0; pix_en = 1'b1; ovf_clr = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk({tag, "_mosr"},      32'(mosr),      32'h0F);
        chk({tag, "_busy"},      32'(busy),      32'h0);
        chk({tag, "_hold_full"}, 32'(hold_full), 32'h0);
        chk({tag, "_ovf"},       32'(ovf),       32'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; pix_en = 1'b0; gld = 1'b0; hflip = 1'b0; ovf_clr = 1'b0;
        gfx = '0; color = '0;
        w1 = {8'hFF, 8'h00, 8'hF0, 8'h0F};
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_mosr",      32'(mosr),      32'h0F);
        chk("rst_busy",      32'(busy),      32'h0);
        chk("rst_hold_full", 32'(hold_full), 32'h0);
        chk("rst_ovf",       32'(ovf),       32'h0);
        chk_en = 1'b1;

        // Single word, left-to-right.
        @(negedge clk);
        load_word(w1, 1'b0, 3'd5); pix_en = 1'b1;
        @(negedge clk);
        gld = 1'b0;
        chk("lat_blank", 32'(mosr), 32'h0F);
        for (int i = 0; i < 9; i++) begin @(negedge clk); s[i] = mosr; end
        for (int i = 0; i < 4; i++) chk("fwd_left",  32'(s[i]),   32'h5A);
        for (int i = 0; i < 4; i++) chk("fwd_right", 32'(s[i+4]), 32'h59);
        chk("fwd_after", 32'(s[8]), 32'h0F);

        // Same word mirrored.
        load_word(w1, 1'b1, 3'd5);
        @(negedge clk);
        gld = 1'b0;
        for (int i = 0; i < 9; i++) begin @(negedge clk); s[i] = mosr; end
        for (int i = 0; i < 4; i++) chk("rev_first",  32'(s[i]),   32'h59);
        for (int i = 0; i < 4; i++) chk("rev_second", 32'(s[i+4]), 32'h5A);
        chk("rev_after", 32'(s[8]), 32'h0F);

        // Back-to-back words: second load while the first is shifting.
        load_word(32'h1234_5678, 1'b0, 3'd2);
        @(negedge clk); gld = 1'b0;
        repeat (3) @(negedge clk);
        load_word(32'h9ABC_DEF0, 1'b1, 3'd6);
        @(negedge clk); gld = 1'b0;
        repeat (16) @(negedge clk);

        // Overflow: two loads while the shifter is frozen.
        pix_en = 1'b0;
        load_word(32'hA5A5_0FF0, 1'b0, 3'd1);
        @(negedge clk); gld = 1'b0; pix_en = 1'b1;
        @(negedge clk); pix_en = 1'b0; load_word(32'h0000_FFFF, 1'b0, 3'd3);
        @(negedge clk); load_word(32'hFFFF_0000, 1'b1, 3'd7);
        @(negedge clk); gld = 1'b0;
        chk("ovf_set", 32'(ovf), 32'h1);
        pix_en = 1'b1;
        repeat (18) @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        chk("ovf_clr", 32'(ovf), 32'h0);

        // Overflow again, then reset in the middle of a word.
        pix_en = 1'b0;
        load_word(32'h3C3C_C3C3, 1'b0, 3'd4);
        @(negedge clk); gld = 1'b0; pix_en = 1'b1;
        @(negedge clk); pix_en = 1'b0; load_word(32'h1111_2222, 1'b0, 3'd2);
        @(negedge clk); load_word(32'h4444_8888, 1'b0, 3'd6);
        @(negedge clk); gld = 1'b0; pix_en = 1'b1;
        @(negedge clk);
        pulse_reset_check("rst_mid");

        // Randomized: pixel enable every 4th clock, then random enable density.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (cyc < 1200) pix_en = ((cyc % 4) == 0);
            else            pix_en = ($urandom_range(0, 3) != 0);
            gld     = (cyc < 1200) ? ($urandom_range(0, 13) == 0) : ($urandom_range(0, 6) == 0);
            gfx     = $urandom;
            hflip   = $urandom_range(0, 1);
            color   = 3'($urandom_range(0, 7));
            ovf_clr = ($urandom_range(0, 15) == 0);
            if (cyc == 2200) pulse_reset_check("rst_rand");
        end
        @(negedge clk);
        gld = 1'b0; pix_en = 1'b1; ovf_clr = 1'b0;
        repeat (24) @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
